// File: rtl/axi_sif_pkg.sv
// Shared layout helpers for the axi_slave_if_v2 channel info words.
// Field offsets count from the LSB of each packed info word.
package axi_sif_pkg;

  localparam int AX_BURST_LSB = 0;
  localparam int AX_SIZE_LSB  = 2;
  localparam int AX_LEN_LSB   = 5;
  localparam int AX_ADDR_LSB  = 13;
  localparam int AX_FIXED_W   = 13;

  localparam int B_RESP_LSB   = 0;
  localparam int B_ID_LSB     = 2;

  localparam int R_LAST_LSB   = 0;
  localparam int R_RESP_LSB   = 1;
  localparam int R_DATA_LSB   = 3;

  localparam int W_STRB_LSB   = 0;

  function automatic int ax_info_w(input int id_w, input int user_w, input int addr_w);
    return id_w + user_w + addr_w + AX_FIXED_W;
  endfunction

  function automatic int w_info_w(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int b_info_w(input int id_w);
    return id_w + 2;
  endfunction

  function automatic int r_info_w(input int id_w, input int data_w);
    return id_w + data_w + 3;
  endfunction

endpackage

// File: rtl/axi_sif_fifo.sv
// First-word-fall-through FIFO with occupancy count and almost-full threshold.
// Pushes when full and pops when empty are ignored.
module axi_sif_fifo #(
  parameter int DW      = 8,
  parameter int AW_LOG2 = 2,
  parameter int AFULL   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout,
  output logic              full,
  output logic              afull,
  output logic              empty,
  output logic [AW_LOG2:0]  count
);

  localparam int DEPTH = 1 << AW_LOG2;

  logic [DW-1:0]      mem [DEPTH];
  logic [AW_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW_LOG2:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == (AW_LOG2+1)'(DEPTH));
  assign afull   = (count_q >= (AW_LOG2+1)'(AFULL));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axi_slave_if_v2.sv
// AXI4 slave front-end: five channel FIFOs plus outstanding-transaction limits.
// Define AXI_SIF_WLAST_CHK_EN to enable the sticky W framing checker (wlast_err).
module axi_slave_if_v2
  import axi_sif_pkg::*;
#(
  parameter int C_AW            = 32,
  parameter int C_UW            = 16,
  parameter int C_ID            = 16,
  parameter int C_DW            = 128,
  parameter int C_AX_DEPTH_LOG2 = 2,
  parameter int C_W_DEPTH_LOG2  = 4,
  parameter int C_R_DEPTH_LOG2  = 4,
  parameter int C_R_AFULL       = 14,
  parameter int C_MAX_WOST      = 8,
  parameter int C_MAX_ROST      = 8
) (
  input  logic                            aclk_s,
  input  logic                            rst_n,
  input  logic [C_ID-1:0]                 awid_s,
  input  logic [C_UW-1:0]                 awuser_s,
  input  logic [C_AW-1:0]                 awaddr_s,
  input  logic [7:0]                      awlen_s,
  input  logic [2:0]                      awsize_s,
  input  logic [1:0]                      awburst_s,
  input  logic                            awvalid_s,
  output logic                            awready_s,
  input  logic [C_DW-1:0]                 wdata_s,
  input  logic [C_DW/8-1:0]               wstrb_s,
  input  logic                            wlast_s,
  input  logic                            wvalid_s,
  output logic                            wready_s,
  output logic [C_ID-1:0]                 bid_s,
  output logic [1:0]                      bresp_s,
  output logic                            bvalid_s,
  input  logic                            bready_s,
  input  logic [C_ID-1:0]                 arid_s,
  input  logic [C_UW-1:0]                 aruser_s,
  input  logic [C_AW-1:0]                 araddr_s,
  input  logic [7:0]                      arlen_s,
  input  logic [2:0]                      arsize_s,
  input  logic [1:0]                      arburst_s,
  input  logic                            arvalid_s,
  output logic                            arready_s,
  output logic [C_ID-1:0]                 rid_s,
  output logic [C_DW-1:0]                 rdata_s,
  output logic [1:0]                      rresp_s,
  output logic                            rlast_s,
  output logic                            rvalid_s,
  input  logic                            rready_s,
  input  logic                            awch_pop,
  input  logic                            arch_pop,
  input  logic                            wch_pop,
  output logic [C_ID+C_UW+C_AW+12:0]      awch_info_o,
  output logic [C_ID+C_UW+C_AW+12:0]      arch_info_o,
  output logic                            awch_empty,
  output logic                            arch_empty,
  output logic                            wch_empty,
  output logic [C_DW+C_DW/8:0]            wch_info_o,
  input  logic [C_ID+1:0]                 bch_info_i,
  input  logic                            bch_push,
  output logic                            bch_full,
  input  logic [C_ID+C_DW+2:0]            rch_info_i,
  input  logic                            rch_push,
  output logic                            rch_full,
  output logic [C_W_DEPTH_LOG2:0]         wch_count,
  output logic [C_R_DEPTH_LOG2:0]         rch_count,
  output logic [7:0]                      wost_cnt,
  output logic [7:0]                      rost_cnt,
  output logic                            wlast_err
);

  localparam int AX_INFO_W = ax_info_w(C_ID, C_UW, C_AW);
  localparam int W_INFO_W  = w_info_w(C_DW);
  localparam int B_INFO_W  = b_info_w(C_ID);
  localparam int R_INFO_W  = r_info_w(C_ID, C_DW);
  localparam int AX_DEPTH  = 1 << C_AX_DEPTH_LOG2;

  logic                  aw_full, ar_full, w_full, b_empty, r_empty;
  logic                  aw_hs, ar_hs, w_hs, b_hs, r_last_hs;
  logic [B_INFO_W-1:0]   b_dout;
  logic [R_INFO_W-1:0]   r_dout;
  logic [7:0]            wost_q, wost_d, rost_q, rost_d;
  logic                  aw_unused_afull, ar_unused_afull, w_unused_afull, b_unused_afull, r_unused_full;
  logic [C_AX_DEPTH_LOG2:0] aw_unused_cnt, ar_unused_cnt, b_unused_cnt;

  // Ready is gated by the registered count only, so a same-cycle B/R never frees a slot.
  assign awready_s = ~aw_full & (wost_q < 8'(C_MAX_WOST));
  assign arready_s = ~ar_full & (rost_q < 8'(C_MAX_ROST));
  assign wready_s  = ~w_full;
  assign bvalid_s  = ~b_empty;
  assign rvalid_s  = ~r_empty;

  assign aw_hs     = awvalid_s & awready_s;
  assign ar_hs     = arvalid_s & arready_s;
  assign w_hs      = wvalid_s & wready_s;
  assign b_hs      = bvalid_s & bready_s;
  assign r_last_hs = rvalid_s & rready_s & rlast_s;

  assign bid_s     = b_dout[B_ID_LSB +: C_ID];
  assign bresp_s   = b_dout[B_RESP_LSB +: 2];
  assign rid_s     = r_dout[R_INFO_W-1 -: C_ID];
  assign rdata_s   = r_dout[R_DATA_LSB +: C_DW];
  assign rresp_s   = r_dout[R_RESP_LSB +: 2];
  assign rlast_s   = r_dout[R_LAST_LSB];

  assign wost_cnt  = wost_q;
  assign rost_cnt  = rost_q;

  axi_sif_fifo #(.DW(AX_INFO_W), .AW_LOG2(C_AX_DEPTH_LOG2), .AFULL(AX_DEPTH)) u_aw_fifo (
    .clk(aclk_s), .rst_n(rst_n), .push(aw_hs), .pop(awch_pop),
    .din({awid_s, awuser_s, awaddr_s, awlen_s, awsize_s, awburst_s}),
    .dout(awch_info_o), .full(aw_full), .afull(aw_unused_afull), .empty(awch_empty),
    .count(aw_unused_cnt));

  axi_sif_fifo #(.DW(AX_INFO_W), .AW_LOG2(C_AX_DEPTH_LOG2), .AFULL(AX_DEPTH)) u_ar_fifo (
    .clk(aclk_s), .rst_n(rst_n), .push(ar_hs), .pop(arch_pop),
    .din({arid_s, aruser_s, araddr_s, arlen_s, arsize_s, arburst_s}),
    .dout(arch_info_o), .full(ar_full), .afull(ar_unused_afull), .empty(arch_empty),
    .count(ar_unused_cnt));

  axi_sif_fifo #(.DW(W_INFO_W), .AW_LOG2(C_W_DEPTH_LOG2), .AFULL(1 << C_W_DEPTH_LOG2)) u_w_fifo (
    .clk(aclk_s), .rst_n(rst_n), .push(w_hs), .pop(wch_pop),
    .din({wlast_s, wdata_s, wstrb_s}),
    .dout(wch_info_o), .full(w_full), .afull(w_unused_afull), .empty(wch_empty),
    .count(wch_count));

  axi_sif_fifo #(.DW(B_INFO_W), .AW_LOG2(C_AX_DEPTH_LOG2), .AFULL(AX_DEPTH)) u_b_fifo (
    .clk(aclk_s), .rst_n(rst_n), .push(bch_push), .pop(b_hs),
    .din(bch_info_i),
    .dout(b_dout), .full(bch_full), .afull(b_unused_afull), .empty(b_empty),
    .count(b_unused_cnt));

  axi_sif_fifo #(.DW(R_INFO_W), .AW_LOG2(C_R_DEPTH_LOG2), .AFULL(C_R_AFULL)) u_r_fifo (
    .clk(aclk_s), .rst_n(rst_n), .push(rch_push), .pop(rvalid_s & rready_s),
    .din(rch_info_i),
    .dout(r_dout), .full(r_unused_full), .afull(rch_full), .empty(r_empty),
    .count(rch_count));

  // Decrements saturate at zero; simultaneous increment and decrement cancel.
  always_comb begin
    wost_d = wost_q;
    rost_d = rost_q;
    if (aw_hs && !b_hs)                     wost_d = wost_q + 8'd1;
    else if (!aw_hs && b_hs && wost_q != 0) wost_d = wost_q - 8'd1;
    if (ar_hs && !r_last_hs)                rost_d = rost_q + 8'd1;
    else if (!ar_hs && r_last_hs && rost_q != 0) rost_d = rost_q - 8'd1;
  end

  always_ff @(posedge aclk_s or negedge rst_n) begin
    if (!rst_n) begin
      wost_q <= '0;
      rost_q <= '0;
    end else begin
      wost_q <= wost_d;
      rost_q <= rost_d;
    end
  end

`ifdef AXI_SIF_WLAST_CHK_EN
  logic [7:0] beat_q, beat_d;
  logic       wlast_err_q, wlast_err_d;
  logic       w_pop_act, head_wlast;
  logic [7:0] head_len;

  assign head_len   = awch_info_o[AX_LEN_LSB +: 8];
  assign head_wlast = wch_info_o[W_INFO_W-1];
  assign w_pop_act  = wch_pop & ~wch_empty & ~awch_empty;
  assign wlast_err  = wlast_err_q;

  // Beats are only attributed to a burst while an AW head is present.
  always_comb begin
    beat_d      = beat_q;
    wlast_err_d = wlast_err_q;
    if (w_pop_act) begin
      if (head_wlast != (beat_q == head_len)) wlast_err_d = 1'b1;
      beat_d = head_wlast ? 8'd0 : beat_q + 8'd1;
    end
  end

  always_ff @(posedge aclk_s or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      wlast_err_q <= wlast_err_d;
    end
  end
`else
  assign wlast_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_slave_if_v2.sv
// Directed scoreboard bench for axi_slave_if_v2 at default parameters.
// wlast_err expectation follows AXI_SIF_WLAST_CHK_EN.
module tb_axi_slave_if_v2;

  logic         aclk_s = 1'b0;
  logic         rst_n;
  logic [15:0]  awid_s, awuser_s;
  logic [31:0]  awaddr_s;
  logic [7:0]   awlen_s;
  logic [2:0]   awsize_s;
  logic [1:0]   awburst_s;
  logic         awvalid_s, awready_s;
  logic [127:0] wdata_s;
  logic [15:0]  wstrb_s;
  logic         wlast_s, wvalid_s, wready_s;
  logic [15:0]  bid_s;
  logic [1:0]   bresp_s;
  logic         bvalid_s, bready_s;
  logic [15:0]  arid_s, aruser_s;
  logic [31:0]  araddr_s;
  logic [7:0]   arlen_s;
  logic [2:0]   arsize_s;
  logic [1:0]   arburst_s;
  logic         arvalid_s, arready_s;
  logic [15:0]  rid_s;
  logic [127:0] rdata_s;
  logic [1:0]   rresp_s;
  logic         rlast_s, rvalid_s, rready_s;
  logic         awch_pop, arch_pop, wch_pop;
  logic [76:0]  awch_info_o, arch_info_o;
  logic         awch_empty, arch_empty, wch_empty;
  logic [144:0] wch_info_o;
  logic [17:0]  bch_info_i;
  logic         bch_push, bch_full;
  logic [146:0] rch_info_i;
  logic         rch_push, rch_full;
  logic [4:0]   wch_count, rch_count;
  logic [7:0]   wost_cnt, rost_cnt;
  logic         wlast_err;

  logic [76:0]  ax_q[$];
  logic [144:0] w_q[$];
  logic [17:0]  b_q[$];
  logic [146:0] r_q[$];
  logic [146:0] r_exp;
  logic [127:0] dpat;

  int checks = 0;
  int errors = 0;

`ifdef AXI_SIF_WLAST_CHK_EN
  localparam logic EXP_WERR = 1'b1;
`else
  localparam logic EXP_WERR = 1'b0;
`endif

  axi_slave_if_v2 dut (
    .aclk_s(aclk_s), .rst_n(rst_n),
    .awid_s(awid_s), .awuser_s(awuser_s), .awaddr_s(awaddr_s), .awlen_s(awlen_s),
    .awsize_s(awsize_s), .awburst_s(awburst_s), .awvalid_s(awvalid_s), .awready_s(awready_s),
    .wdata_s(wdata_s), .wstrb_s(wstrb_s), .wlast_s(wlast_s), .wvalid_s(wvalid_s), .wready_s(wready_s),
    .bid_s(bid_s), .bresp_s(bresp_s), .bvalid_s(bvalid_s), .bready_s(bready_s),
    .arid_s(arid_s), .aruser_s(aruser_s), .araddr_s(araddr_s), .arlen_s(arlen_s),
    .arsize_s(arsize_s), .arburst_s(arburst_s), .arvalid_s(arvalid_s), .arready_s(arready_s),
    .rid_s(rid_s), .rdata_s(rdata_s), .rresp_s(rresp_s), .rlast_s(rlast_s),
    .rvalid_s(rvalid_s), .rready_s(rready_s),
    .awch_pop(awch_pop), .arch_pop(arch_pop), .wch_pop(wch_pop),
    .awch_info_o(awch_info_o), .arch_info_o(arch_info_o),
    .awch_empty(awch_empty), .arch_empty(arch_empty), .wch_empty(wch_empty),
    .wch_info_o(wch_info_o),
    .bch_info_i(bch_info_i), .bch_push(bch_push), .bch_full(bch_full),
    .rch_info_i(rch_info_i), .rch_push(rch_push), .rch_full(rch_full),
    .wch_count(wch_count), .rch_count(rch_count),
    .wost_cnt(wost_cnt), .rost_cnt(rost_cnt), .wlast_err(wlast_err)
  );

  always #5 aclk_s = ~aclk_s;

  // Advance n clock edges; inputs change and outputs are sampled 1ns after each edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge aclk_s);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setAw(input int i, input logic [7:0] len);
    awid_s    = 16'(i + 1);
    awuser_s  = 16'(16'hA0 + i);
    awaddr_s  = 32'(32'h1000 + i * 16);
    awlen_s   = len;
    awsize_s  = 3'd4;
    awburst_s = 2'd1;
  endtask

  task automatic drainAw(input int n);
    for (int k = 0; k < n; k++) begin
      checkOutput("aw_info", 256'(awch_info_o), 256'(ax_q.pop_front()));
      awch_pop = 1'b1;
      applyStimulus(1);
    end
    awch_pop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awid_s = '0; awuser_s = '0; awaddr_s = '0; awlen_s = '0; awsize_s = '0; awburst_s = '0; awvalid_s = 1'b0;
    wdata_s = '0; wstrb_s = '0; wlast_s = 1'b0; wvalid_s = 1'b0; bready_s = 1'b0;
    arid_s = '0; aruser_s = '0; araddr_s = '0; arlen_s = '0; arsize_s = '0; arburst_s = '0; arvalid_s = 1'b0;
    rready_s = 1'b0; awch_pop = 1'b0; arch_pop = 1'b0; wch_pop = 1'b0;
    bch_info_i = '0; bch_push = 1'b0; rch_info_i = '0; rch_push = 1'b0;
    applyStimulus(2);
    checkOutput("rst_ready", 256'({awready_s, wready_s, arready_s}), 256'(3'b111));
    checkOutput("rst_valid", 256'({bvalid_s, rvalid_s}), 256'(0));
    checkOutput("rst_empty", 256'({awch_empty, arch_empty, wch_empty}), 256'(3'b111));
    checkOutput("rst_full", 256'({bch_full, rch_full}), 256'(0));
    checkOutput("rst_counts", 256'({wch_count, rch_count, wost_cnt, rost_cnt}), 256'(0));
    checkOutput("rst_wlast_err", 256'(wlast_err), 256'(0));
    rst_n = 1'b1;
    applyStimulus(1);

    $display("[TB] AW FIFO fill to depth 4");
    for (int i = 0; i < 4; i++) begin
      setAw(i, 8'(i));
      awvalid_s = 1'b1;
      ax_q.push_back({awid_s, awuser_s, awaddr_s, awlen_s, awsize_s, awburst_s});
      checkOutput("aw_ready_before_full", 256'(awready_s), 256'(1));
      applyStimulus(1);
    end
    awvalid_s = 1'b0;
    checkOutput("aw_full_ready", 256'(awready_s), 256'(0));
    checkOutput("aw_full_empty", 256'(awch_empty), 256'(0));
    checkOutput("aw_full_wost", 256'(wost_cnt), 256'(4));
    drainAw(4);
    checkOutput("aw_drained_empty", 256'(awch_empty), 256'(1));
    checkOutput("aw_drained_ready", 256'(awready_s), 256'(1));

    $display("[TB] outstanding write limit");
    for (int i = 4; i < 8; i++) begin
      setAw(i, 8'd0);
      awvalid_s = 1'b1;
      ax_q.push_back({awid_s, awuser_s, awaddr_s, awlen_s, awsize_s, awburst_s});
      applyStimulus(1);
    end
    awvalid_s = 1'b0;
    checkOutput("wost_at_limit", 256'(wost_cnt), 256'(8));
    drainAw(4);
    checkOutput("wost_limit_fifo_empty", 256'(awch_empty), 256'(1));
    checkOutput("wost_limit_ready", 256'(awready_s), 256'(0));
    bch_info_i = {16'h0077, 2'b10};
    b_q.push_back(bch_info_i);
    bch_push = 1'b1;
    applyStimulus(1);
    bch_push = 1'b0;
    checkOutput("b_valid", 256'(bvalid_s), 256'(1));
    checkOutput("b_info", 256'({bid_s, bresp_s}), 256'(b_q.pop_front()));
    bready_s = 1'b1;
    setAw(9, 8'd0);
    awvalid_s = 1'b1;
    checkOutput("limit_b_same_cycle_ready", 256'(awready_s), 256'(0));
    applyStimulus(1);
    bready_s = 1'b0;
    awvalid_s = 1'b0;
    checkOutput("wost_after_b", 256'(wost_cnt), 256'(7));
    checkOutput("aw_ready_after_b", 256'(awready_s), 256'(1));
    checkOutput("aw_not_taken_at_limit", 256'(awch_empty), 256'(1));
    checkOutput("b_drained", 256'(bvalid_s), 256'(0));

    $display("[TB] AR burst of 4 beats");
    arid_s = 16'h0055; aruser_s = 16'h1234; araddr_s = 32'h2000; arlen_s = 8'd3;
    arsize_s = 3'd4; arburst_s = 2'd1; arvalid_s = 1'b1;
    ax_q.push_back({arid_s, aruser_s, araddr_s, arlen_s, arsize_s, arburst_s});
    applyStimulus(1);
    arvalid_s = 1'b0;
    checkOutput("rost_after_ar", 256'(rost_cnt), 256'(1));
    checkOutput("ar_info", 256'(arch_info_o), 256'(ax_q.pop_front()));
    arch_pop = 1'b1;
    applyStimulus(1);
    arch_pop = 1'b0;
    checkOutput("ar_drained", 256'(arch_empty), 256'(1));
    for (int i = 0; i < 4; i++) begin
      dpat = {4{32'(32'hC0DE0000 + i)}};
      rch_info_i = {16'h0055, dpat, 2'b00, (i == 3)};
      r_q.push_back(rch_info_i);
      rch_push = 1'b1;
      applyStimulus(1);
    end
    rch_push = 1'b0;
    checkOutput("r_count_4", 256'(rch_count), 256'(4));
    rready_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_exp = r_q.pop_front();
      checkOutput("r_beat_id", 256'(rid_s), 256'(r_exp[146:131]));
      checkOutput("r_beat_data", 256'(rdata_s), 256'(r_exp[130:3]));
      checkOutput("r_beat_last", 256'(rlast_s), 256'(r_exp[0]));
      applyStimulus(1);
      checkOutput("rost_per_beat", 256'(rost_cnt), 256'((i == 3) ? 0 : 1));
    end
    rready_s = 1'b0;
    checkOutput("r_drained", 256'(rvalid_s), 256'(0));

    $display("[TB] R almost-full threshold");
    for (int i = 0; i < 14; i++) begin
      dpat = {4{32'(32'h5EED0000 + i)}};
      rch_info_i = {16'(16'h0100 + i), dpat, 2'b01, (i == 0)};
      r_q.push_back(rch_info_i);
      rch_push = 1'b1;
      applyStimulus(1);
      checkOutput("r_afull_step", 256'(rch_full), 256'((i + 1 >= 14) ? 1 : 0));
    end
    rch_push = 1'b0;
    checkOutput("r_count_14", 256'(rch_count), 256'(14));
    rready_s = 1'b1;
    for (int i = 0; i < 14; i++) begin
      r_exp = r_q.pop_front();
      checkOutput("r_fill_id", 256'(rid_s), 256'(r_exp[146:131]));
      checkOutput("r_fill_data", 256'(rdata_s), 256'(r_exp[130:3]));
      applyStimulus(1);
      if (i == 0) begin
        checkOutput("r_count_13", 256'(rch_count), 256'(13));
        checkOutput("r_afull_clear", 256'(rch_full), 256'(0));
        checkOutput("rost_saturate", 256'(rost_cnt), 256'(0));
      end
    end
    rready_s = 1'b0;
    checkOutput("r_fill_drained", 256'(rvalid_s), 256'(0));

    $display("[TB] W FIFO push/pop");
    for (int i = 0; i < 5; i++) begin
      wdata_s = {4{32'(32'h11110000 + i)}};
      wstrb_s = 16'(16'hFF00 + i);
      wlast_s = 1'b0;
      wvalid_s = 1'b1;
      w_q.push_back({wlast_s, wdata_s, wstrb_s});
      applyStimulus(1);
      if (i == 0) checkOutput("w_fwft_empty", 256'(wch_empty), 256'(0));
    end
    wvalid_s = 1'b0;
    checkOutput("w_count_5", 256'(wch_count), 256'(5));
    wdata_s = {4{32'h22220000}};
    wstrb_s = 16'h0F0F;
    wlast_s = 1'b1;
    wvalid_s = 1'b1;
    w_q.push_back({wlast_s, wdata_s, wstrb_s});
    checkOutput("w_info_simul", 256'(wch_info_o), 256'(w_q.pop_front()));
    wch_pop = 1'b1;
    applyStimulus(1);
    wvalid_s = 1'b0;
    wch_pop = 1'b0;
    checkOutput("w_count_simul", 256'(wch_count), 256'(5));
    for (int i = 0; i < 5; i++) begin
      checkOutput("w_info", 256'(wch_info_o), 256'(w_q.pop_front()));
      wch_pop = 1'b1;
      applyStimulus(1);
    end
    wch_pop = 1'b0;
    checkOutput("w_drained", 256'(wch_empty), 256'(1));

    $display("[TB] W framing check");
    setAw(12, 8'd1);
    awvalid_s = 1'b1;
    ax_q.push_back({awid_s, awuser_s, awaddr_s, awlen_s, awsize_s, awburst_s});
    applyStimulus(1);
    awvalid_s = 1'b0;
    wdata_s = {4{32'h33330000}};
    wstrb_s = 16'hFFFF;
    wlast_s = 1'b1;
    wvalid_s = 1'b1;
    applyStimulus(1);
    wvalid_s = 1'b0;
    wlast_s = 1'b0;
    wch_pop = 1'b1;
    applyStimulus(1);
    wch_pop = 1'b0;
    checkOutput("wlast_err_set", 256'(wlast_err), 256'(EXP_WERR));
    drainAw(1);
    applyStimulus(2);
    checkOutput("wlast_err_sticky", 256'(wlast_err), 256'(EXP_WERR));
    rst_n = 1'b0;
    #1;
    checkOutput("wlast_err_reset", 256'(wlast_err), 256'(0));
    checkOutput("wost_reset", 256'(wost_cnt), 256'(0));
    applyStimulus(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
